// File: rtl/count_pkg.sv
// Shared definitions for the saturating step counter and its capture block.
package count_pkg;

   // Counter data width and the last value of i that still advances.
   localparam int unsigned W     = 10;
   localparam int unsigned LIMIT = 250;

   // Capture block run phases.
   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CLEAR = 2'd3
   } state_e;

endpackage : count_pkg

// File: rtl/count_sat_capture.sv
// Watches a saturating step counter, checks its sn/i pairing, times each run,
// hands one record per run over valid/ready, then requests a counter clear.
module count_sat_capture
   import count_pkg::*;
#(
   parameter int unsigned W     = count_pkg::W,
   parameter int unsigned LIMIT = count_pkg::LIMIT,
   parameter int unsigned CW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  sn_in,
   input  logic [W-1:0]  i_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_sn,
   output logic [CW-1:0] out_cycles,
   output logic          out_bad,
   output logic          err,
   output logic          clr_req
);

   state_e        state_q, state_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          run_bad_q, run_bad_d;
   logic [W-1:0]  out_sn_q, out_sn_d;
   logic [CW-1:0] out_cycles_q, out_cycles_d;
   logic          out_bad_q, out_bad_d;
   logic          err_q, err_d;

   logic          start_seen;
   logic          sat_seen;
   logic          pair_bad;
   logic          sn_off;
   logic [W-1:0]  pair_diff;
   logic [CW-1:0] cyc_inc;

   // Counter sitting at its reset value marks a clean run start.
   assign start_seen = (i_in == W'(1)) && (sn_in == '0);
   assign sat_seen   = (i_in > W'(LIMIT));
   // i leads sn by exactly one step; the subtraction wraps mod 2^W.
   assign pair_diff  = i_in - sn_in;
   assign pair_bad   = (pair_diff != W'(1));
   assign sn_off     = (sn_in != W'(LIMIT));
   // Run-time counter sticks at all-ones instead of wrapping.
   assign cyc_inc    = (&cyc_q) ? cyc_q : cyc_q + CW'(1);

   // Next-state, run bookkeeping and record capture.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      cyc_d        = cyc_q;
      run_bad_d    = run_bad_q;
      out_sn_d     = out_sn_q;
      out_cycles_d = out_cycles_q;
      out_bad_d    = out_bad_q;
      err_d        = err_q;

      unique case (state_q)
         ST_WAIT: begin
            if (start_seen) begin
               state_d   = ST_RUN;
               cyc_d     = '0;
               run_bad_d = 1'b0;
            end
         end

         ST_RUN: begin
            cyc_d = cyc_inc;
            if (pair_bad) begin
               run_bad_d = 1'b1;
               err_d     = 1'b1;
            end
            if (sat_seen) begin
               out_sn_d     = sn_in;
               // Includes the detect cycle, so a run stepping every cycle
               // from i=1 reports exactly LIMIT.
               out_cycles_d = cyc_inc;
               out_bad_d    = run_bad_q | pair_bad | sn_off;
               if (sn_off) begin
                  err_d = 1'b1;
               end
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_CLEAR;
            end
         end

         ST_CLEAR: begin
            state_d = ST_WAIT;
         end

         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // State and record registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q      <= ST_WAIT;
         cyc_q        <= '0;
         run_bad_q    <= 1'b0;
         out_sn_q     <= '0;
         out_cycles_q <= '0;
         out_bad_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         run_bad_q    <= run_bad_d;
         out_sn_q     <= out_sn_d;
         out_cycles_q <= out_cycles_d;
         out_bad_q    <= out_bad_d;
         err_q        <= err_d;
      end
   end

   assign out_valid  = (state_q == ST_HOLD);
   assign clr_req    = (state_q == ST_CLEAR);
   assign out_sn     = out_sn_q;
   assign out_cycles = out_cycles_q;
   assign out_bad    = out_bad_q;
   assign err        = err_q;

endmodule : count_sat_capture
